// File: rtl/if_fetch.sv
// Fetch unit: looks PCs up in a direct-mapped I-cache and refills misses byte by byte.
// Hit latency 1 cycle, miss 5+ cycles; stall_o throttles pc_reg, id_stall_i holds the output.
module if_fetch #(
  parameter int ICACHE_IDX = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [31:0] pc_i,
  input  logic        pc_e_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        id_stall_i
);

  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAG_W = 30 - ICACHE_IDX;

  typedef enum logic {ST_IDLE, ST_FETCH} state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } line_t;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] fbuf_q, fbuf_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_v_q, inst_v_d;

  logic [LINES-1:0] lv_q;
  line_t            line_mem [LINES];

  logic [31:0]           lk_pc;
  logic [ICACHE_IDX-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  line_t                 lk_line;
  logic                  lk_hit;
  logic                  hold;
  logic                  accept;
  logic                  wr_en;
  logic [ICACHE_IDX-1:0] wr_idx;
  line_t                 wr_line;

  // A parked PC always takes precedence over the live pc_i.
  assign lk_pc   = pend_v_q ? pend_pc_q : pc_i;
  assign lk_idx  = lk_pc[ICACHE_IDX+1:2];
  assign lk_tag  = lk_pc[31:ICACHE_IDX+2];
  assign lk_line = line_mem[lk_idx];
  assign lk_hit  = lv_q[lk_idx] && (lk_line.tag == lk_tag);

  assign hold    = inst_v_q & id_stall_i;
  assign stall_o = (state_q == ST_FETCH) | pend_v_q | hold;
  assign accept  = rdy & ~flush_i & (state_q == ST_IDLE) & ~hold &
                   ((pc_e_i & ~stall_o) | pend_v_q);

  assign mem_req_o  = (state_q == ST_FETCH);
  assign mem_addr_o = mem_req_o ? (fpc_q + {30'd0, cnt_q}) : 32'd0;

  // The last byte completes a correct line even if a flush kills its delivery.
  assign wr_en        = rdy & (state_q == ST_FETCH) & mem_ack_i & (cnt_q == 2'd3);
  assign wr_idx       = fpc_q[ICACHE_IDX+1:2];
  assign wr_line.tag  = fpc_q[31:ICACHE_IDX+2];
  assign wr_line.data = {mem_data_i, fbuf_q};

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_v_q;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    cnt_d     = cnt_q;
    fbuf_d    = fbuf_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    inst_v_d  = inst_v_q;
    if (rdy) begin
      if (flush_i) begin
        state_d  = ST_IDLE;
        pend_v_d = 1'b0;
        inst_v_d = 1'b0;
      end else begin
        inst_v_d = hold;
        if (pc_e_i && stall_o && !pend_v_q) begin
          pend_v_d  = 1'b1;
          pend_pc_d = pc_i;
        end
        if (accept) begin
          pend_v_d = 1'b0;
          if (lk_hit) begin
            inst_d    = lk_line.data;
            inst_pc_d = lk_pc;
            inst_v_d  = 1'b1;
          end else begin
            fpc_d   = lk_pc;
            cnt_d   = 2'd0;
            state_d = ST_FETCH;
          end
        end
        if (state_q == ST_FETCH && mem_ack_i) begin
          cnt_d = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: fbuf_d[7:0]   = mem_data_i;
            2'd1: fbuf_d[15:8]  = mem_data_i;
            2'd2: fbuf_d[23:16] = mem_data_i;
            default: begin
              inst_d    = {mem_data_i, fbuf_q};
              inst_pc_d = fpc_q;
              inst_v_d  = 1'b1;
              state_d   = ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      fpc_q     <= '0;
      cnt_q     <= '0;
      fbuf_q    <= '0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      inst_v_q  <= 1'b0;
      lv_q      <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      cnt_q     <= cnt_d;
      fbuf_q    <= fbuf_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      inst_v_q  <= inst_v_d;
      if (wr_en) lv_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_idx] <= wr_line;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic against a tag-array model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_e_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_data_i = '0;
  logic        id_stall_i = 1'b0;
  logic        stall_o, mem_req_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o, inst_pc_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_pct = 100;

  logic [7:0]  mem [4096];
  logic        ref_v [64];
  logic [23:0] ref_tag [64];

  if_fetch #(.ICACHE_IDX(6)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .pc_i(pc_i), .pc_e_i(pc_e_i),
    .flush_i(flush_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .id_stall_i(id_stall_i)
  );

  always #5 clk = ~clk;

  // Byte memory answers the current request a little after each edge.
  always @(posedge clk) begin
    #2;
    if (mem_req_o && ($urandom_range(99) < ack_pct)) begin
      mem_ack_i  = 1'b1;
      mem_data_i = mem[mem_addr_o[11:0]];
    end else begin
      mem_ack_i  = 1'b0;
      mem_data_i = 8'($urandom);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a);
    pc_i   = a;
    pc_e_i = 1'b1;
    step();
    pc_e_i = 1'b0;
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !inst_valid_o; i++) step();
    n_cmp++;
    if (inst_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL valid_timeout: got %b want 1", inst_valid_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({stall_o, mem_req_o, inst_valid_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 000", {stall_o, mem_req_o, inst_valid_o}); end
    n_cmp++; if ({mem_addr_o, inst_o, inst_pc_o} !== 96'd0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h want 0", mem_addr_o, inst_o, inst_pc_o); end
    @(negedge clk) rst_n = 1'b1;
    step();
    n_cmp++; if ({stall_o, mem_req_o, inst_valid_o} !== 3'b000) begin
      n_bad++; $display("FAIL post_reset_ctl: got %b want 000", {stall_o, mem_req_o, inst_valid_o}); end
  endtask

  task automatic test_cold_miss_pending();
    present(32'h0);
    n_cmp++; if ({stall_o, mem_req_o} !== 2'b11 || mem_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL miss_enter: got %b addr %h want 11 addr 0", {stall_o, mem_req_o}, mem_addr_o); end
    pc_i = 32'h4; pc_e_i = 1'b1;
    step();
    pc_e_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      n_cmp++; if (mem_addr_o !== 32'(k) || stall_o !== 1'b1 || inst_valid_o !== 1'b0) begin
        n_bad++; $display("FAIL fetch_step%0d: got addr %h stall %b v %b want addr %0d stall 1 v 0",
                          k, mem_addr_o, stall_o, inst_valid_o, k); end
      step();
    end
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100513 || inst_pc_o !== 32'h0) begin
      n_bad++; $display("FAIL cold_fill: got v %b %h @%h want 1 00100513 @0", inst_valid_o, inst_o, inst_pc_o); end
    n_cmp++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL pend_stall: got stall %b req %b want 1 0", stall_o, mem_req_o); end
    step();
    n_cmp++; if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4 || stall_o !== 1'b1) begin
      n_bad++; $display("FAIL pend_fetch: got v %b req %b addr %h stall %b want 0 1 4 1",
                        inst_valid_o, mem_req_o, mem_addr_o, stall_o); end
    wait_valid(20);
    n_cmp++; if (inst_o !== word(32'h4) || inst_pc_o !== 32'h4 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL pend_fill: got %h @%h stall %b want %h @4 stall 0", inst_o, inst_pc_o, stall_o, word(32'h4)); end
    step();
    n_cmp++; if (inst_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL pulse_drop: got %b want 0", inst_valid_o); end
  endtask

  task automatic test_hit();
    present(32'h0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100513 || inst_pc_o !== 32'h0 || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL hit0: got v %b %h @%h req %b want 1 00100513 @0 0",
                        inst_valid_o, inst_o, inst_pc_o, mem_req_o); end
    present(32'h4);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== word(32'h4) || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL hit4: got v %b %h req %b want 1 %h 0", inst_valid_o, inst_o, mem_req_o, word(32'h4)); end
    step();
  endtask

  task automatic test_flush();
    present(32'h8);
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin
      n_bad++; $display("FAIL flush_miss: got req %b addr %h want 1 8", mem_req_o, mem_addr_o); end
    repeat (2) step();
    flush_i = 1'b1; pc_i = 32'hC; pc_e_i = 1'b1;
    step();
    flush_i = 1'b0; pc_e_i = 1'b0;
    n_cmp++; if ({mem_req_o, inst_valid_o, stall_o} !== 3'b000) begin
      n_bad++; $display("FAIL flush_kill: got %b want 000", {mem_req_o, inst_valid_o, stall_o}); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({mem_req_o, inst_valid_o} !== 2'b00) begin
        n_bad++; $display("FAIL flush_quiet%0d: got %b want 00", i, {mem_req_o, inst_valid_o}); end
    end
    present(32'h8);
    n_cmp++; if (mem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL flush_remiss: got %b want 1", mem_req_o); end
    wait_valid(20);
    n_cmp++; if (inst_o !== word(32'h8) || inst_pc_o !== 32'h8) begin
      n_bad++; $display("FAIL flush_refill: got %h @%h want %h @8", inst_o, inst_pc_o, word(32'h8)); end
    step();
  endtask

  task automatic test_id_stall();
    present(32'h0);
    id_stall_i = 1'b1; pc_i = 32'h4; pc_e_i = 1'b1;
    step();
    pc_i = 32'h8;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00100513 || inst_pc_o !== 32'h0 ||
                   stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
        n_bad++; $display("FAIL id_hold%0d: got v %b %h @%h stall %b req %b want 1 00100513 @0 1 0",
                          i, inst_valid_o, inst_o, inst_pc_o, stall_o, mem_req_o); end
      if (i < 2) step();
      pc_e_i = 1'b0;
    end
    id_stall_i = 1'b0;
    step();
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h4 || inst_o !== word(32'h4) || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL id_release: got v %b %h @%h stall %b want 1 %h @4 0",
                        inst_valid_o, inst_o, inst_pc_o, stall_o, word(32'h4)); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({inst_valid_o, mem_req_o} !== 2'b00) begin
        n_bad++; $display("FAIL id_ignored%0d: got %b want 00", i, {inst_valid_o, mem_req_o}); end
    end
  endtask

  task automatic test_evict_and_reset();
    logic [31:0] seq [3];
    logic [31:0] a;
    seq[0] = 32'h100; seq[1] = 32'h0; seq[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      a = seq[i];
      present(a);
      n_cmp++; if (mem_req_o !== 1'b1) begin
        n_bad++; $display("FAIL evict_miss%0d: got %b want 1", i, mem_req_o); end
      wait_valid(20);
      n_cmp++; if (inst_o !== word(a) || inst_pc_o !== a) begin
        n_bad++; $display("FAIL evict_fill%0d: got %h @%h want %h @%h", i, inst_o, inst_pc_o, word(a), a); end
      step();
    end
    present(32'h208);
    repeat (2) step();
    rst_n = 1'b0;
    #3;
    n_cmp++; if ({stall_o, mem_req_o, inst_valid_o} !== 3'b000 || {mem_addr_o, inst_o, inst_pc_o} !== 96'd0) begin
      n_bad++; $display("FAIL midfill_reset: got %b %h %h %h want all 0",
                        {stall_o, mem_req_o, inst_valid_o}, mem_addr_o, inst_o, inst_pc_o); end
    @(negedge clk) rst_n = 1'b1;
    step();
    present(32'h100);
    n_cmp++; if (mem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_clears_cache: got %b want 1", mem_req_o); end
    wait_valid(20);
    n_cmp++; if (inst_o !== word(32'h100)) begin
      n_bad++; $display("FAIL reset_refill: got %h want %h", inst_o, word(32'h100)); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] held;
    logic [5:0]  idx;
    logic        exp_miss, saw_req;
    int          cyc, k;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
    step();
    for (int t = 0; t < 60; t++) begin
      idx = 6'($urandom_range(7));
      a = {22'd0, 2'($urandom_range(3)), idx, 2'b00};
      exp_miss = !(ref_v[idx] && ref_tag[idx] == a[31:8]);
      for (int i = 0; i < 50 && stall_o; i++) step();
      ack_pct = $urandom_range(100, 30);
      rdy = 1'b1;
      present(a);
      saw_req = 1'b0;
      cyc = 0;
      while (!inst_valid_o && cyc < 400) begin
        saw_req |= mem_req_o;
        rdy = ($urandom_range(3) != 0);
        step();
        cyc++;
      end
      rdy = 1'b1;
      n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== word(a) || inst_pc_o !== a) begin
        n_bad++; $display("FAIL rand%0d_inst: got v %b %h @%h want 1 %h @%h", t, inst_valid_o, inst_o, inst_pc_o, word(a), a); end
      n_cmp++; if (saw_req !== exp_miss) begin
        n_bad++; $display("FAIL rand%0d_hitmiss: got miss %b want %b (pc %h)", t, saw_req, exp_miss, a); end
      ref_v[idx] = 1'b1;
      ref_tag[idx] = a[31:8];
      if ($urandom_range(1) == 1) begin
        held = inst_o;
        k = $urandom_range(3, 1);
        id_stall_i = 1'b1;
        repeat (k) step();
        n_cmp++; if (inst_valid_o !== 1'b1 || inst_o !== held) begin
          n_bad++; $display("FAIL rand%0d_hold: got v %b %h want 1 %h", t, inst_valid_o, inst_o, held); end
        id_stall_i = 1'b0;
      end
      step();
      n_cmp++; if (inst_valid_o !== 1'b0) begin
        n_bad++; $display("FAIL rand%0d_drop: got %b want 0", t, inst_valid_o); end
    end
    ack_pct = 100;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    test_reset();
    test_cold_miss_pending();
    test_hit();
    test_flush();
    test_id_stall();
    test_evict_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
